// File: rtl/of_sched_pkg.sv
// Shared types and constants for the OF-stage issue scoreboard.
package of_sched_pkg;

  localparam int NREGS        = 32;
  localparam int REG_W        = 5;
  localparam int MAX_INFLIGHT = 4;
  localparam int INFL_W       = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sched_state_t;

  // One-hot decode of a register number into a NREGS-wide bitmap.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << r;
  endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW hazard detection against the pending-write bitmap.
// A register being written back this cycle is treated as no longer pending.
module sb_hazard_check
  import of_sched_pkg::*;
(
  input  logic [NREGS-1:0] pend,
  input  logic [NREGS-1:0] wb_dec,
  input  logic [REG_W-1:0] rp1,
  input  logic [REG_W-1:0] rp2,
  input  logic             use1,
  input  logic             use2,
  input  logic             dst_we,
  input  logic [REG_W-1:0] dst,
  output logic             hazard
);

  logic [NREGS-1:0] eff;

  // Pending bits with same-cycle writebacks bypassed, then the three lookups.
  always_comb begin
    eff    = pend & ~wb_dec;
    hazard = (use1 & eff[rp1]) | (use2 & eff[rp2]) | (dst_we & eff[dst]);
  end

endmodule

// File: rtl/of_issue_scoreboard.sv
// Issue scoreboard for the operand-fetch stage: tracks pending register
// writes, produces stall/issue, and sequences a halt through a drain phase.
module of_issue_scoreboard
  import of_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  rp1,
  input  logic [REG_W-1:0]  rp2,
  input  logic              use1,
  input  logic              use2,
  input  logic              dst_we,
  input  logic [REG_W-1:0]  dst,
  input  logic              stop,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_port,
  output logic              stall,
  output logic              issue,
  output logic [NREGS-1:0]  pend,
  output logic [INFL_W-1:0] inflight,
  output logic              halted
);

  sched_state_t     state;
  logic [NREGS-1:0] wb_dec;
  logic [NREGS-1:0] set_dec;
  logic             wb_valid;
  logic             full;
  logic             hazard;
  logic             alloc;

  sb_hazard_check u_hazard (
    .pend   (pend),
    .wb_dec (wb_dec),
    .rp1    (rp1),
    .rp2    (rp2),
    .use1   (use1),
    .use2   (use2),
    .dst_we (dst_we),
    .dst    (dst),
    .hazard (hazard)
  );

  // Writeback decode, capacity check and the zero-latency stall/issue decision.
  always_comb begin
    wb_dec   = wb_en ? reg_onehot(wb_port) : '0;
    wb_valid = wb_en & pend[wb_port];
    // A valid writeback this cycle frees a slot, so a full table can still issue.
    full     = (inflight == INFL_W'(MAX_INFLIGHT)) & ~wb_valid;
    stall    = (state == ST_RUN) ? (id_valid & (hazard | full)) : 1'b1;
    issue    = (state == ST_RUN) & id_valid & ~stall & ~flush & ~stop;
    alloc    = issue & dst_we;
    set_dec  = alloc ? reg_onehot(dst) : '0;
  end

  // Pending bitmap and in-flight count; a new issue to a register wins over
  // its simultaneous writeback. Flush deliberately leaves both untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      inflight <= '0;
    end else begin
      pend <= (pend & ~(wb_valid ? wb_dec : '0)) | set_dec;
      case ({alloc, wb_valid})
        2'b10:   inflight <= inflight + INFL_W'(1);
        2'b01:   inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Halt sequencing: a halt in OF drains outstanding writes, then stays halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (id_valid & stop & ~flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (inflight == '0) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_of_issue_scoreboard.sv
// Scoreboard bench for of_issue_scoreboard: a driver computes expected
// outputs from a set-of-pending-registers model, a monitor compares.
module tb_of_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  rp1, rp2, dst, wb_port;
  logic        use1, use2, dst_we, stop, flush, wb_en;
  logic        stall, issue, halted;
  logic [31:0] pend;
  logic [2:0]  inflight;

  of_issue_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .id_valid (id_valid),
    .rp1      (rp1),
    .rp2      (rp2),
    .use1     (use1),
    .use2     (use2),
    .dst_we   (dst_we),
    .dst      (dst),
    .stop     (stop),
    .flush    (flush),
    .wb_en    (wb_en),
    .wb_port  (wb_port),
    .stall    (stall),
    .issue    (issue),
    .pend     (pend),
    .inflight (inflight),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [31:0] pend;
    logic [2:0]  inflight;
    logic        halted;
  } obs_t;

  obs_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: which registers await a write, and the core mode.
  bit   mpend[32];
  int   mmode;       // 0 running, 1 draining, 2 halted

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mpend[i]);
    return c;
  endfunction

  function automatic logic [31:0] mvec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  // Drive one cycle of inputs, predict the outputs, advance the model.
  task automatic step(input logic r, input logic iv,
                      input logic [4:0] a, input logic u1,
                      input logic [4:0] b, input logic u2,
                      input logic we, input logic [4:0] d,
                      input logic st, input logic fl,
                      input logic wbe, input logic [4:0] wp);
    obs_t e;
    bit   busy_a, busy_b, busy_d, haz, wbok, full_e, stall_e, iss_e;
    int   cnt;
    @(posedge clk); #1;
    reset = r; id_valid = iv; rp1 = a; use1 = u1; rp2 = b; use2 = u2;
    dst_we = we; dst = d; stop = st; flush = fl; wb_en = wbe; wb_port = wp;

    cnt    = mcount();
    busy_a = mpend[a] && !(wbe && wp == a);
    busy_b = mpend[b] && !(wbe && wp == b);
    busy_d = mpend[d] && !(wbe && wp == d);
    haz    = (u1 && busy_a) || (u2 && busy_b) || (we && busy_d);
    wbok   = wbe && mpend[wp];
    full_e = (cnt == 4) && !wbok;
    stall_e = (mmode == 0) ? (iv && (haz || full_e)) : 1'b1;
    iss_e   = (mmode == 0) && iv && !stall_e && !fl && !st;
    e.stall    = stall_e;
    e.issue    = iss_e;
    e.pend     = mvec();
    e.inflight = 3'(cnt);
    e.halted   = (mmode == 2);
    expq.push_back(e);

    if (r) begin
      for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
      mmode = 0;
    end else begin
      if (wbok) mpend[wp] = 1'b0;
      if (iss_e && we) mpend[d] = 1'b1;
      if (mmode == 0 && iv && st && !fl) mmode = 1;
      else if (mmode == 1 && cnt == 0) mmode = 2;
    end
  endtask

  task automatic idle(input logic wbe, input logic [4:0] wp);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wbe, wp);
  endtask

  // Monitor: compare the DUT against the oldest prediction, mid-cycle.
  always @(negedge clk) begin
    obs_t e;
    obs_t got;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = '{stall, issue, pend, inflight, halted};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cycle_check t=%0t got stall=%b issue=%b pend=%h inflight=%0d halted=%b want stall=%b issue=%b pend=%h inflight=%0d halted=%b",
                 $time, got.stall, got.issue, got.pend, got.inflight, got.halted,
                 e.stall, e.issue, e.pend, e.inflight, e.halted);
      end
    end
  end

  initial begin
    reset = 1; id_valid = 0; rp1 = 0; rp2 = 0; use1 = 0; use2 = 0;
    dst_we = 0; dst = 0; stop = 0; flush = 0; wb_en = 0; wb_port = 0;
    mmode = 0;
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state is observed on the first checked cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Read-after-write on r5 stalls until r5 writes back (bypassed that cycle).
    step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5);

    // Fill four slots, fifth waits on capacity until a writeback frees one.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 2);
    idle(0, 0);

    // Re-issue to r7 while r7 writes back: stays pending, count unchanged.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7);
    idle(0, 0);

    // Flush suppresses issue; writeback to non-pending r9 is ignored.
    step(0, 1, 0, 0, 0, 0, 1, 8, 0, 1, 0, 0);
    idle(1, 9);
    idle(0, 0);

    // Halt with two pending writes: drain, then halted and sticky.
    step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1, 7);
    idle(0, 0);
    idle(1, 3);
    idle(0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);

    // Reset in the middle of a drain; late writeback then ignored.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 10);
    idle(0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic       r, iv, u1, u2, we, st, fl, wbe;
      logic [4:0] a, b, d, wp;
      int         pl[$];
      r   = (mmode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      iv  = $urandom_range(0, 3) != 0;
      u1  = $urandom_range(0, 1) != 0;
      u2  = $urandom_range(0, 1) != 0;
      we  = $urandom_range(0, 9) < 7;
      a   = 5'($urandom_range(0, 7));
      b   = 5'($urandom_range(0, 7));
      d   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      fl  = $urandom_range(0, 9) == 0;
      st  = ($urandom_range(0, 59) == 0) && !fl;
      wbe = $urandom_range(0, 1) != 0;
      for (int i = 0; i < 32; i++) if (mpend[i]) pl.push_back(i);
      if (pl.size() > 0 && $urandom_range(0, 3) != 0)
        wp = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        wp = 5'($urandom_range(0, 31));
      step(r, iv, a, u1, b, u2, we, d, st, fl, wbe, wp);
    end

    // Let the monitor consume the last prediction, bounded.
    for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain_queue left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/of_issue_scoreboard.md
OF_ISSUE_SCOREBOARD -- requirements
Module: of_issue_scoreboard

Interface
REQ-001 SHALL have ports: clk in 1 (system clock, all state on rising edge); reset in 1 (synchronous, active-high).
REQ-002 SHALL have inputs: id_valid 1 (instruction present in OF stage); rp1 5, rp2 5 (source read ports); use1 1, use2 1 (source actually read); dst_we 1 (instruction writes a register); dst 5 (destination).
REQ-003 SHALL have inputs: stop 1 (OF stage holds a halt, already flush-gated); flush 1 (branch flush); wb_en 1 (register-file write this cycle); wb_port 5 (written register).
REQ-004 SHALL have outputs: stall 1 (hold PC/IF/OF); issue 1 (OF instruction advances this cycle); pend 32 (pending-write bitmap); inflight 3 (count of pending writes); halted 1 (core halted).
REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-006 pend[r] SHALL set on the cycle after issue=1 with dst_we=1 and dst=r.
REQ-007 pend[r] SHALL clear on the cycle after wb_en=1 with wb_port=r.
REQ-008 Simultaneous set and clear of the same r SHALL leave pend[r]=1 (new issue wins).
REQ-009 A writeback to a register with pend=0 SHALL be ignored for pend and inflight.
REQ-010 Hazard SHALL be (use1 & eff[rp1]) | (use2 & eff[rp2]) | (dst_we & eff[dst]), where eff = pend & ~(wb_en-decoded one-hot of wb_port); i.e. a same-cycle writeback removes the hazard.
REQ-011 full SHALL be inflight==4 & ~(wb_en & pend[wb_port]).
REQ-012 inflight SHALL be +1 on issue with dst_we; -1 on valid writeback (REQ-009); unchanged when both occur; it is never >4 or <0.
REQ-013 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-014 RUN->DRAIN when id_valid & stop & ~flush & ~hazard-free-gating (the halt itself never writes, issue=0).
REQ-015 DRAIN->HALTED when inflight==0 (same-cycle valid writeback reducing inflight to 0 counts on the following cycle).
REQ-016 HALTED SHALL be sticky until reset.
REQ-017 stall SHALL be id_valid & (hazard | full) in RUN, and 1 in DRAIN and HALTED; stall is combinational (zero latency).
REQ-018 issue SHALL be state==RUN & id_valid & ~stall & ~flush & ~stop.
REQ-019 flush SHALL suppress issue that cycle only; it SHALL NOT clear pend or inflight (issued instructions still write back).
REQ-020 halted SHALL equal (state==HALTED), registered.

Reset
REQ-021 On reset: pend=0, inflight=0, state=RUN, halted=0; stall and issue follow REQ-017/018 from that state.
REQ-022 Reset mid-DRAIN SHALL return to RUN with empty scoreboard; writebacks arriving after reset are ignored per REQ-009.

Structure
REQ-023 Package of_sched_pkg SHALL hold the FSM state type, NREGS=32, MAX_INFLIGHT=4, and inflight width.
REQ-024 Hazard evaluation SHALL be one combinational sub-module sb_hazard_check (inputs pend, wb decode, sources, dst; output hazard); the rest is flat.

Verification
REQ-025 Issue dst=5 (dst_we=1); next cycle id_valid, use1=1, rp1=5 -> stall=1, issue=0 until the cycle wb_en=1,wb_port=5, where stall=0, issue=1.
REQ-026 Four issues to r1..r4 with no writeback; fifth instruction dst=r6 -> inflight=4, stall=1; wb r2 same cycle -> stall=0, issue=1, inflight stays 4.
REQ-027 Same cycle: issue dst=7, wb_port=7 with pend[7]=1 -> next cycle pend[7]=1, inflight unchanged.
REQ-028 Two pending writes, then stop=1 -> state DRAIN, stall=1; after both writebacks inflight=0; next cycle halted=1; further id_valid ignored until reset.
REQ-029 flush=1 with id_valid and no hazard -> issue=0, pend unchanged; wb_en to non-pending r9 -> pend and inflight unchanged; reset in DRAIN -> pend=0, inflight=0, halted=0, state RUN.
